qsum: RTL and testbench
=======================

Name: qsum

Overview:
- Reduces the filtered queue stream produced by the field-select filter stage, consuming its output directly.
- Sums the data words of each innermost-level transaction and emits one sum per transaction. The remaining outer eot bits travel with each sum.
- Sits between the filter and the downstream accumulation/statistics logic.
- Interfaces are dti consumer (din) and dti producer (dout).

Parameters:
- W_DIN, 16: width of the din data field, unsigned.
- W_DOUT, 24: width of the sum; must be >= W_DIN.
- LVL, 2: number of din eot bits; must be >= 1. dout carries LVL-1 eot bits, and none when LVL=1.
- SAT, 0: 0 = sum wraps modulo 2^W_DOUT; 1 = sum saturates at 2^W_DOUT-1.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- din.data  input  LVL+W_DIN  packed {eot[LVL-1:0], data[W_DIN-1:0]}; eot[0] marks the last word of the innermost transaction.
- din.valid  input  1  producer has a word.
- din.ready  output  1  qsum accepts the word.
- dout.data  output  (LVL-1)+W_DOUT  packed {eot[LVL-1:1], sum[W_DOUT-1:0]}.
- dout.valid  output  1  sum register holds an unconsumed result.
- dout.ready  input  1  consumer accepts the result.

Behaviour:
- Handshakes: a handshake occurs when valid && ready in the same cycle. dout.valid never depends combinationally on dout.ready. Once asserted, dout.valid and dout.data are held stable until the dout handshake.
- State:
  - acc: W_DOUT-bit running accumulator.
  - out_reg: dout.data register.
  - out_valid: drives dout.valid.
- Reset (rst=0 at a clock edge): acc=0, out_reg=0, out_valid=0.
  - Applies mid-transaction: partial sums and any pending result are discarded.
  - din.ready is still computed combinationally during reset, but accepted words have no effect.
- nxt = acc + zero-extended din.data.
  - SAT=0: nxt is truncated to W_DOUT bits.
  - SAT=1: on carry out, nxt becomes all-ones. Once saturated, acc stays all-ones for the rest of the transaction.
- din handshake with eot[0]=0: acc <= nxt. No output activity. Accepted every cycle regardless of out_valid.
- din handshake with eot[0]=1:
  - out_reg.sum <= nxt and out_reg.eot <= din eot[LVL-1:1].
  - out_valid <= 1 and acc <= 0.
  - Latency: the result appears on dout the cycle after the final word is accepted.
- din.ready = !(din.valid && din eot[0] && out_valid && !dout.ready).
  - Non-final words always flow.
  - A final word stalls only while a previous result is held and not being consumed.
- Simultaneous events:
  - dout handshake and final-word load in the same cycle: the new result loads and out_valid stays 1. One result per cycle is sustained.
  - dout handshake with no final-word load: out_valid <= 0; out_reg keeps its value (don't-care).
- Single-word transaction (eot[0] on the first word): sum = that word.
- Back-to-back transactions: acc clears when the final word is accepted, so the next cycle's word starts a new sum.
- Outer-level eot bits of non-final words are ignored. Only the final word's eot[LVL-1:1] is forwarded.
- LVL=1: dout.data = sum only.
- No combinational path from din to dout. din.ready depends combinationally on din.data, din.valid and dout.ready.

Test Plan:
- Basic sum (W_DIN=16, W_DOUT=24, LVL=2): words 3, 5, 7 with eot=00, 00, 01 and dout.ready=1 -> one dout word {eot=0, sum=15}, valid the cycle after the 7 is accepted.
- Outer eot forwarding: transaction words 10, 20 with the final word eot=11 -> dout {eot=1, sum=30}. A following single word 9 with eot=01 -> dout {eot=0, sum=9} on the next cycle. Back-to-back results with no bubble.
- Backpressure: dout.ready=0 while result 15 is held; next transaction 1, 2(eot) -> the 1 is accepted, din.ready=0 on the 2. Raise dout.ready -> 15 is consumed, the 2 is accepted the same cycle, and dout shows 3 next cycle.
- Wrap vs saturate (W_DOUT=16, W_DIN=16): 0xFFFF, 0x0002(eot) -> SAT=0 gives sum 0x0001; SAT=1 gives 0xFFFF.
- Reset mid-operation: accept 4, 4 (no eot), assert rst=0 for 1 cycle, then send 6(eot) -> dout sum=6 with eot=0. A result pending during reset is dropped and dout.valid=0 the cycle after reset.
- Random valid/ready (10k words, random eot[0] at 25% density) -> dout sequence matches the reference-model per-transaction sums. dout.data is stable while valid && !ready, and no word is lost or duplicated.

Source files
------------

// File: rtl/qsum.sv
// -----------------------------------------------------------------------------
// qsum -- per-transaction sum reducer for the filtered queue stream.
//
// Adds up the data words of each innermost-level transaction (the run of words
// ending with eot[0]=1) and emits one sum per transaction. The final word's
// outer eot bits eot[LVL-1:1] are forwarded with the sum.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-low reset
//   din_data    {eot[LVL-1:0], data[W_DIN-1:0]}; eot[0] marks the last word
//   din_valid   producer has a word
//   din_ready   qsum accepts the word
//   dout_data   {eot[LVL-1:1], sum[W_DOUT-1:0]}; sum only when LVL=1
//   dout_valid  a result is held and not yet consumed
//   dout_ready  consumer accepts the result
//
// Parameters:
//   W_DIN   data width (unsigned)
//   W_DOUT  sum width, >= W_DIN
//   LVL     number of din eot bits, >= 1
//   SAT     0: sum wraps modulo 2^W_DOUT, 1: sum saturates at all-ones
// -----------------------------------------------------------------------------
module qsum #(
    parameter int W_DIN  = 16,
    parameter int W_DOUT = 24,
    parameter int LVL    = 2,
    parameter int SAT    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LVL+W_DIN-1:0]    din_data,
    input  logic                    din_valid,
    output logic                    din_ready,
    output logic [LVL+W_DOUT-2:0]   dout_data,
    output logic                    dout_valid,
    input  logic                    dout_ready
);

    localparam int W_OUT = LVL - 1 + W_DOUT;

    logic [W_DIN-1:0]  din_word;
    logic              din_last;
    logic [W_DOUT:0]   sum_full;
    logic [W_DOUT-1:0] acc;
    logic [W_DOUT-1:0] nxt;
    logic [W_OUT-1:0]  load_word;
    logic [W_OUT-1:0]  out_reg;
    logic              out_valid;
    logic              din_fire;
    logic              dout_fire;

    assign din_word = din_data[W_DIN-1:0];
    assign din_last = din_data[W_DIN];

    // One extra bit captures the carry out of the accumulator.
    assign sum_full = {1'b0, acc} + {{(W_DOUT + 1 - W_DIN){1'b0}}, din_word};

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        nxt = sum_full[W_DOUT-1:0];
        // Once acc is all-ones, any nonzero word carries again, so a saturated
        // sum stays saturated for the rest of the transaction.
        if (SAT != 0 && sum_full[W_DOUT]) begin
            nxt = '1;
        end
    end

    // Only the final word's outer eot bits travel with the sum.
    generate
        if (LVL > 1) begin : g_eot
            assign load_word = {din_data[LVL+W_DIN-1:W_DIN+1], nxt};
        end else begin : g_no_eot
            assign load_word = nxt;
        end
    endgenerate

    // A final word stalls only while an older result is held and not being
    // taken this cycle; non-final words always flow.
    assign din_ready = !(din_valid && din_last && out_valid && !dout_ready);

    assign din_fire  = din_valid && din_ready;
    assign dout_fire = out_valid && dout_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // Reset wins over any handshake in the same cycle: partial sums and
            // a pending result are both discarded.
            acc       <= '0;
            out_reg   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (din_fire) begin
                acc <= din_last ? '0 : nxt;
            end
            // A load in the same cycle as a consume keeps out_valid high, so
            // one result per cycle is sustained.
            if (din_fire && din_last) begin
                out_reg   <= load_word;
                out_valid <= 1'b1;
            end else if (dout_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign dout_data  = out_reg;
    assign dout_valid = out_valid;

endmodule

// File: tb/tb_qsum.sv
// -----------------------------------------------------------------------------
// tb_qsum -- self-checking bench for qsum.
//
// The main instance (W_DIN=16, W_DOUT=24, LVL=2, SAT=0) is checked every cycle
// against a transaction-level model: a queue of expected results, a running
// sum, and the ready rule. Two small 16-bit instances pin wrap vs saturate
// (the saturating one also covers LVL=1).
// -----------------------------------------------------------------------------
module tb_qsum;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    // Main instance.
    logic [17:0] din_data   = '0;
    logic        din_valid  = 1'b0;
    logic        din_ready;
    logic [24:0] dout_data;
    logic        dout_valid;
    logic        dout_ready = 1'b0;

    qsum #(.W_DIN(16), .W_DOUT(24), .LVL(2), .SAT(0)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .din_data   (din_data),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout_data  (dout_data),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    // Wrapping 16-bit instance.
    logic [17:0] w_din   = '0;
    logic        w_valid = 1'b0;
    logic        w_ready;
    logic [16:0] w_dout;
    logic        w_ovalid;
    logic        ws_rdy  = 1'b1;

    qsum #(.W_DIN(16), .W_DOUT(16), .LVL(2), .SAT(0)) u_wrap (
        .clk        (clk),
        .rst        (rst),
        .din_data   (w_din),
        .din_valid  (w_valid),
        .din_ready  (w_ready),
        .dout_data  (w_dout),
        .dout_valid (w_ovalid),
        .dout_ready (ws_rdy)
    );

    // Saturating 16-bit instance with a single eot level.
    logic [16:0] s_din   = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_dout;
    logic        s_ovalid;

    qsum #(.W_DIN(16), .W_DOUT(16), .LVL(1), .SAT(1)) u_sat (
        .clk        (clk),
        .rst        (rst),
        .din_data   (s_din),
        .din_valid  (s_valid),
        .din_ready  (s_ready),
        .dout_data  (s_dout),
        .dout_valid (s_ovalid),
        .dout_ready (ws_rdy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model of the main instance.
    // ------------------------------------------------------------------
    logic [24:0] m_q[$];
    int          m_acc     = 0;
    int          m_sum     = 0;
    bit          m_held    = 1'b0;
    bit          m_take;
    int          m_pushed  = 0;
    int          m_dropped = 0;
    int          dut_outs  = 0;
    bit          chk_en    = 1'b0;

    wire m_ready = !(din_valid && din_data[16] && m_held && !dout_ready);

    always @(posedge clk) begin
        if (!rst) begin
            m_dropped += m_q.size();
            m_q.delete();
            m_acc = 0;
        end else begin
            m_take = din_valid && m_ready;
            if (m_held && dout_ready) begin
                m_q.delete(0);
            end
            if (m_take) begin
                m_sum = (m_acc + int'(din_data[15:0])) & 32'h00FF_FFFF;
                if (din_data[16]) begin
                    m_q.push_back({din_data[17], m_sum[23:0]});
                    m_pushed++;
                    m_acc = 0;
                end else begin
                    m_acc = m_sum;
                end
            end
        end
        m_held = (m_q.size() != 0);
    end

    always @(posedge clk) begin
        if (rst && dout_valid && dout_ready) begin
            dut_outs++;
        end
    end

    // Every-cycle comparison, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_valid", dout_valid, m_held);
            if (m_held) begin
                check("cmp_data", dout_data, m_q[0]);
            end
            check("cmp_ready", din_ready, m_ready);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at posedge+1, return at next posedge+1).
    // ------------------------------------------------------------------
    task automatic cyc(input bit v, input bit [1:0] e, input int d, input bit r,
                       input bit exp_rdy, input string nm);
        din_valid  = v;
        din_data   = {e, d[15:0]};
        dout_ready = r;
        #1;
        check({nm, "_rdy"}, din_ready, exp_rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic ws(input int d, input bit e0, input bit e1);
        w_din   = {e1, e0, d[15:0]};
        s_din   = {e0, d[15:0]};
        w_valid = 1'b1;
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        w_valid = 1'b0;
        s_valid = 1'b0;
    endtask

    int          acc_words = 0;
    int          cyc_n     = 0;
    logic [31:0] r;

    initial begin
        // Reset.
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b1;
        chk_en = 1'b1;
        check("rst_valid", dout_valid, 0);
        check("rst_ready", din_ready, 1);
        check("rst_wrap_valid", w_ovalid, 0);

        // Basic sum 3+5+7.
        cyc(1, 2'b00, 3, 1, 1, "b3");
        cyc(1, 2'b00, 5, 1, 1, "b5");
        check("b_mid_valid", dout_valid, 0);
        cyc(1, 2'b01, 7, 1, 1, "b7");
        check("b_valid", dout_valid, 1);
        check("b_sum", dout_data, 25'h000_000F);
        cyc(0, 2'b00, 0, 1, 1, "b_idle");
        check("b_consumed", dout_valid, 0);

        // Outer eot forwarding, back-to-back results.
        cyc(1, 2'b00, 10, 1, 1, "o10");
        cyc(1, 2'b11, 20, 1, 1, "o20");
        check("o_sum30", dout_data, 25'h100_001E);
        cyc(1, 2'b01, 9, 1, 1, "o9");
        check("o_b2b_valid", dout_valid, 1);
        check("o_sum9", dout_data, 25'h000_0009);
        cyc(0, 2'b00, 0, 1, 1, "o_idle");
        check("o_consumed", dout_valid, 0);

        // Backpressure; the outer eot on the non-final 1 must be ignored.
        cyc(1, 2'b01, 15, 0, 1, "p15");
        check("p_held15", dout_data, 25'h000_000F);
        cyc(1, 2'b10, 1, 0, 1, "p1");
        cyc(1, 2'b01, 2, 0, 0, "p2_stall");
        check("p_still15", dout_data, 25'h000_000F);
        check("p_still_valid", dout_valid, 1);
        cyc(1, 2'b01, 2, 1, 1, "p2_go");
        check("p_sum3", dout_data, 25'h000_0003);
        cyc(0, 2'b00, 0, 1, 1, "p_idle");
        check("p_consumed", dout_valid, 0);

        // Reset mid-transaction discards the partial 4+4.
        cyc(1, 2'b00, 4, 1, 1, "r4a");
        cyc(1, 2'b00, 4, 1, 1, "r4b");
        rst = 1'b0;
        cyc(0, 2'b00, 0, 1, 1, "r_idle");
        rst = 1'b1;
        cyc(1, 2'b01, 6, 1, 1, "r6");
        check("r_sum6", dout_data, 25'h000_0006);
        cyc(0, 2'b00, 0, 1, 1, "r_idle2");

        // Reset drops a pending result; the word offered during reset is lost.
        cyc(1, 2'b11, 5, 0, 1, "d5");
        check("d_pending", dout_valid, 1);
        rst = 1'b0;
        cyc(1, 2'b01, 8, 0, 0, "d_rst");
        rst = 1'b1;
        check("d_dropped", dout_valid, 0);
        cyc(0, 2'b00, 0, 1, 1, "d_idle");

        // Wrap vs saturate.
        ws(32'hFFFF, 1'b0, 1'b0);
        ws(32'h0002, 1'b1, 1'b0);
        check("ws_wrap_valid", w_ovalid, 1);
        check("ws_wrap_sum", w_dout, 17'h0_0001);
        check("ws_sat_sum", s_dout, 16'hFFFF);
        ws(32'hFFFF, 1'b0, 1'b0);
        ws(32'h0001, 1'b0, 1'b0);
        ws(32'h0000, 1'b1, 1'b1);
        check("ws_wrap_sum0", w_dout, 17'h1_0000);
        check("ws_sat_hold", s_dout, 16'hFFFF);
        ws(32'h1234, 1'b1, 1'b0);
        check("ws_wrap_single", w_dout, 17'h0_1234);
        check("ws_sat_single", s_dout, 16'h1234);

        // Random valid/ready traffic.
        while (acc_words < 10000 && cyc_n < 60000) begin
            r          = $urandom();
            din_valid  = ($urandom_range(0, 3) != 0);
            din_data   = {r[17], (r[21:20] == 2'b00), r[15:0]};
            dout_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (din_valid && m_ready) acc_words++;
            @(posedge clk);
            #1;
            cyc_n++;
        end
        check("rand_words", acc_words, 10000);

        // Close the last transaction, then drain.
        cyc_n = 0;
        din_valid  = 1'b1;
        din_data   = {2'b01, 16'h0001};
        dout_ready = 1'b1;
        #1;
        while (!m_ready && cyc_n < 10) begin
            @(posedge clk);
            #1;
            cyc_n++;
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("drain_empty", m_q.size(), 0);
        check("no_loss_dup", dut_outs, m_pushed - m_dropped);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
